uart_frame_serializer: RTL

Parametrised successor to the combinational UART frame generator. Accepts a data word plus per-frame configuration over a valid/ready handshake and latches it. It assembles the frame with internally computed parity, then shifts the frame out LSB-first on tx, one bit per baud_tick. It sits between the transmit data source and the baud generator and drives the UART TX pin directly.

---
 rtl/uart_pkg.sv | 44 ++++
 rtl/uart_frame_serializer_builder.sv | 57 +++++
 rtl/uart_frame_serializer.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the UART frame serializer.
// Holds parity codes, FSM states, frame sizing constants, and the length/parity helpers.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  localparam logic [3:0] DATA_LEN_MIN   = 4'd5;
  localparam int         FRAME_OVERHEAD = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_SHIFT      = 2'd2
  } ser_state_e;

  // Keep the requested data length inside 5..max_len.
  function automatic logic [3:0] clamp_len(input logic [3:0] raw_len, input logic [3:0] max_len);
    logic [3:0] len_v;
    if (raw_len < DATA_LEN_MIN) begin
      len_v = DATA_LEN_MIN;
    end else if (raw_len > max_len) begin
      len_v = max_len;
    end else begin
      len_v = raw_len;
    end
    return len_v;
  endfunction

  // Parity over already-masked data bits; PAR_NONE returns 1 (idle level, never placed).
  function automatic logic calc_parity(input logic [15:0] data_bits, input logic [1:0] ptype);
    logic par_v;
    case (ptype)
      PAR_EVEN: par_v = ^data_bits;
      PAR_ODD:  par_v = ~(^data_bits);
      PAR_MARK: par_v = 1'b1;
      default:  par_v = 1'b1;
    endcase
    return par_v;
  endfunction

endpackage

// File: rtl/uart_frame_serializer_builder.sv
// Combinational UART frame assembly: start, LSB-first data, optional parity, stop bits.
// Bits above the last stop bit read as idle (1).
module uart_frame_builder
  import uart_pkg::*;
#(
  parameter int DATA_W = 9,
  localparam int FRAME_W = DATA_W + FRAME_OVERHEAD
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [3:0]         len,
  input  logic [1:0]         parity_type,
  input  logic               stop_bits,
  output logic [FRAME_W-1:0] frame,
  output logic [3:0]         frame_len
);

  logic [DATA_W-1:0]  data_masked_s;
  logic [FRAME_W-1:0] data_shift_s;
  logic               par_en_s;
  logic               par_bit_s;

  // Mask unused data bits and shift the payload above the start bit.
  always_comb begin
    data_masked_s = '0;
    data_shift_s  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(len)) begin
        data_masked_s[i] = data[i];
      end else begin
        data_masked_s[i] = 1'b0;
      end
    end
    data_shift_s[DATA_W:1] = data;
  end

  assign par_en_s  = (parity_type != PAR_NONE);
  assign par_bit_s = calc_parity({{(16-DATA_W){1'b0}}, data_masked_s}, parity_type);

  // Place each frame bit; stop bits and padding fall through to 1.
  always_comb begin
    frame = '1;
    for (int i = 0; i < FRAME_W; i++) begin
      if (i == 0) begin
        frame[i] = 1'b0;
      end else if (i <= int'(len)) begin
        frame[i] = data_shift_s[i];
      end else if (par_en_s && (i == int'(len) + 1)) begin
        frame[i] = par_bit_s;
      end else begin
        frame[i] = 1'b1;
      end
    end
  end

  assign frame_len = 4'd1 + len + {3'b000, par_en_s} + (stop_bits ? 4'd2 : 4'd1);

endmodule

// File: rtl/uart_frame_serializer.sv
// UART frame serializer: latches a word on valid/ready, then shifts the assembled
// frame out LSB-first on tx, one bit per baud_tick.
module uart_frame_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W = 9,
  localparam int FRAME_W = DATA_W + FRAME_OVERHEAD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               baud_tick,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [3:0]         data_len,
  input  logic [1:0]         parity_type,
  input  logic               stop_bits,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               tx,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_out,
  output logic [3:0]         frame_len
);

  ser_state_e         state_r, state_next_s;
  logic               tx_r, tx_next_s;
  logic [3:0]         cnt_r, cnt_next_s;
  logic               in_ready_r, busy_r;
  logic [FRAME_W-1:0] frame_r;
  logic [3:0]         frame_len_r;
  logic               accept_s;
  logic [3:0]         len_clamped_s;
  logic [FRAME_W-1:0] build_frame_s;
  logic [3:0]         build_len_s;

  assign len_clamped_s = clamp_len(data_len, 4'(DATA_W));

  uart_frame_builder #(.DATA_W(DATA_W)) u_builder (
    .data        (data_in),
    .len         (len_clamped_s),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .frame       (build_frame_s),
    .frame_len   (build_len_s)
  );

  // Next-state, next-tx and bit counter; a tick in the accept cycle is not seen by WAIT_START.
  always_comb begin
    state_next_s = state_r;
    tx_next_s    = tx_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tx_next_s = 1'b1;
        if (in_valid && in_ready_r) begin
          accept_s     = 1'b1;
          state_next_s = ST_WAIT_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT_START: begin
        if (baud_tick) begin
          tx_next_s    = frame_r[0];
          cnt_next_s   = 4'd1;
          state_next_s = ST_SHIFT;
        end else begin
          tx_next_s = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (baud_tick && (cnt_r < frame_len_r)) begin
          tx_next_s  = frame_r[cnt_r];
          cnt_next_s = cnt_r + 4'd1;
        end else if (baud_tick) begin
          tx_next_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          tx_next_s = tx_r;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        tx_next_s    = 1'b1;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // State and output registers; frame data only changes on accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      tx_r        <= 1'b1;
      cnt_r       <= 4'd0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      frame_r     <= '1;
      frame_len_r <= 4'd0;
    end else begin
      state_r    <= state_next_s;
      tx_r       <= tx_next_s;
      cnt_r      <= cnt_next_s;
      in_ready_r <= (state_next_s == ST_IDLE);
      busy_r     <= (state_next_s != ST_IDLE);
      if (accept_s) begin
        frame_r     <= build_frame_s;
        frame_len_r <= build_len_s;
      end
    end
  end

  assign tx        = tx_r;
  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign frame_out = frame_r;
  assign frame_len = frame_len_r;

endmodule
